// File: rtl/branch_resolve_unit_if.sv
// Handshake bundle between the ID stage / IF stage and branch_resolve_unit.
// master drives the ID/IF inputs; slave is the resolver itself.
interface branch_resolve_unit_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 16
);
  logic [PC_W-1:0]   if_pc;
  logic              pred_taken;
  logic              id_valid;
  logic              id_stall;
  logic [5:0]        id_opcode;
  logic [5:0]        id_funct;
  logic [PC_W-1:0]   id_pc;
  logic              id_pred_taken;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic              pc_src;
  logic [1:0]        redirect_sel;
  logic              is_j;
  logic              if_flush;
  logic [CNT_W-1:0]  branch_cnt;
  logic [CNT_W-1:0]  mispred_cnt;

  modport master (
    output if_pc, id_valid, id_stall, id_opcode, id_funct, id_pc,
           id_pred_taken, read_data1, read_data2,
    input  pred_taken, pc_src, redirect_sel, is_j, if_flush,
           branch_cnt, mispred_cnt
  );

  modport slave (
    input  if_pc, id_valid, id_stall, id_opcode, id_funct, id_pc,
           id_pred_taken, read_data1, read_data2,
    output pred_taken, pc_src, redirect_sel, is_j, if_flush,
           branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// ID-stage branch/jump resolver with a bimodal 2-bit BHT feeding IF predictions.
// Define BRANCH_PERF_CNT_EN to build the saturating branch/mispredict counters.
module branch_resolve_unit #(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int BHT_DEPTH = 16,
  parameter int CNT_W     = 16
) (
  input logic clk,
  input logic rst_n,
  branch_resolve_unit_if.slave bus
);
  localparam int IDX_W = $clog2(BHT_DEPTH);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] FN_JR    = 6'b001000;

  logic [1:0]       bht [BHT_DEPTH];
  logic [IDX_W-1:0] ifIdx;
  logic [IDX_W-1:0] idIdx;
  logic             resolve;
  logic             isBeq;
  logic             isBne;
  logic             isBranch;
  logic             isJump;
  logic             isJr;
  logic             operandsEqual;
  logic             taken;
  logic             mispredict;
  logic             trainBranch;
  logic             pcSrc;
  logic [1:0]       redirectSel;
  logic             isJ;
  logic             unusedPcBits;

  assign ifIdx = bus.if_pc[IDX_W+1:2];
  assign idIdx = bus.id_pc[IDX_W+1:2];
  // Only the index slice of each PC addresses the table.
  assign unusedPcBits = ^{bus.if_pc, bus.id_pc};

  assign resolve       = bus.id_valid & ~bus.id_stall;
  assign isBeq         = (bus.id_opcode == OP_BEQ);
  assign isBne         = (bus.id_opcode == OP_BNE);
  assign isBranch      = isBeq | isBne;
  assign isJump        = (bus.id_opcode == OP_J) | (bus.id_opcode == OP_JAL);
  assign isJr          = (bus.id_opcode == OP_RTYPE) & (bus.id_funct == FN_JR);
  assign operandsEqual = (bus.read_data1 == bus.read_data2);
  assign taken         = isBeq ? operandsEqual : ~operandsEqual;
  assign trainBranch   = resolve & isBranch;
  assign mispredict    = trainBranch & (taken != bus.id_pred_taken);

  always_comb begin
    pcSrc       = 1'b0;
    redirectSel = 2'b00;
    isJ         = 1'b0;
    if (resolve) begin
      if (mispredict) begin
        pcSrc       = 1'b1;
        redirectSel = taken ? 2'b00 : 2'b01;
      end else if (isJump) begin
        pcSrc       = 1'b1;
        redirectSel = 2'b10;
        isJ         = 1'b1;
      end else if (isJr) begin
        pcSrc       = 1'b1;
        redirectSel = 2'b11;
        isJ         = 1'b1;
      end
    end
  end

  assign bus.pc_src       = pcSrc;
  assign bus.redirect_sel = redirectSel;
  assign bus.is_j         = isJ;
  assign bus.if_flush     = pcSrc;

  // Read is from the registered table, so a same-cycle update is not visible yet.
  assign bus.pred_taken = bht[ifIdx][1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht[i] <= 2'b01;
      end
    end else if (trainBranch) begin
      if (taken && (bht[idIdx] != 2'b11)) begin
        bht[idIdx] <= bht[idIdx] + 2'b01;
      end else if (!taken && (bht[idIdx] != 2'b00)) begin
        bht[idIdx] <= bht[idIdx] - 2'b01;
      end
    end
  end

`ifdef BRANCH_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] branchCnt;
  logic [CNT_W-1:0] mispredCnt;

  // Both counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branchCnt  <= '0;
      mispredCnt <= '0;
    end else begin
      if (trainBranch && (branchCnt != '1)) begin
        branchCnt <= branchCnt + CNT_ONE;
      end
      if (mispredict && (mispredCnt != '1)) begin
        mispredCnt <= mispredCnt + CNT_ONE;
      end
    end
  end

  assign bus.branch_cnt  = branchCnt;
  assign bus.mispred_cnt = mispredCnt;
`else
  assign bus.branch_cnt  = '0;
  assign bus.mispred_cnt = '0;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: vector table, BHT/counter model, scoreboard.
// Counter expectations follow BRANCH_PERF_CNT_EN as the RTL is built.
module tb_branch_resolve_unit;
  localparam int DATA_W    = 32;
  localparam int PC_W      = 32;
  localparam int BHT_DEPTH = 16;
  localparam int CNT_W     = 4;
  localparam int IDX_W     = $clog2(BHT_DEPTH);
  localparam int CNT_MAX   = (1 << CNT_W) - 1;
`ifdef BRANCH_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] idPc;
    logic [31:0] ifPc;
    logic        pt;
    logic        valid;
    logic        stall;
    logic        expPcSrc;
    logic [1:0]  expSel;
    logic        expIsJ;
  } vecT;

  typedef struct {
    string       name;
    logic        pcSrc;
    logic [1:0]  sel;
    logic        isJ;
    logic        pred;
    logic [31:0] bc;
    logic [31:0] mc;
  } expT;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  vecT  vecs[$];
  expT  expQ[$];
  logic [1:0] modelBht [BHT_DEPTH];
  int   modelBranchCnt;
  int   modelMispredCnt;

  always #5 clk = ~clk;

  branch_resolve_unit_if #(.DATA_W(DATA_W), .PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  branch_resolve_unit #(
    .DATA_W(DATA_W), .PC_W(PC_W), .BHT_DEPTH(BHT_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < BHT_DEPTH; i++) modelBht[i] = 2'b01;
    modelBranchCnt  = 0;
    modelMispredCnt = 0;
  endtask

  task automatic addVec(input string name, input logic [5:0] opcode, input logic [5:0] funct,
                        input logic [31:0] rd1, input logic [31:0] rd2,
                        input logic [31:0] idPc, input logic [31:0] ifPc,
                        input logic pt, input logic valid, input logic stall,
                        input logic expPcSrc, input logic [1:0] expSel, input logic expIsJ);
    vecT v;
    v.name = name; v.opcode = opcode; v.funct = funct; v.rd1 = rd1; v.rd2 = rd2;
    v.idPc = idPc; v.ifPc = ifPc; v.pt = pt; v.valid = valid; v.stall = stall;
    v.expPcSrc = expPcSrc; v.expSel = expSel; v.expIsJ = expIsJ;
    vecs.push_back(v);
  endtask

  function automatic vecT mkVec(input string name, input logic [5:0] opcode,
                                input logic [31:0] rd1, input logic [31:0] rd2,
                                input logic [31:0] pc, input logic pt, input logic valid,
                                input logic stall, input logic expPcSrc,
                                input logic [1:0] expSel);
    vecT v;
    v.name = name; v.opcode = opcode; v.funct = 6'd0; v.rd1 = rd1; v.rd2 = rd2;
    v.idPc = pc; v.ifPc = pc; v.pt = pt; v.valid = valid; v.stall = stall;
    v.expPcSrc = expPcSrc; v.expSel = expSel; v.expIsJ = 1'b0;
    return v;
  endfunction

  task automatic applyStimulus(input vecT v);
    expT e;
    logic [IDX_W-1:0] idx;
    @(negedge clk);
    bus.id_opcode     = v.opcode;
    bus.id_funct      = v.funct;
    bus.read_data1    = v.rd1;
    bus.read_data2    = v.rd2;
    bus.id_pc         = v.idPc;
    bus.if_pc         = v.ifPc;
    bus.id_pred_taken = v.pt;
    bus.id_valid      = v.valid;
    bus.id_stall      = v.stall;
    idx     = v.ifPc[IDX_W+1:2];
    e.name  = v.name;
    e.pcSrc = v.expPcSrc;
    e.sel   = v.expSel;
    e.isJ   = v.expIsJ;
    e.pred  = modelBht[idx][1];
    e.bc    = modelBranchCnt;
    e.mc    = modelMispredCnt;
    expQ.push_back(e);
  endtask

  task automatic checkOutput();
    expT e;
    #1;
    if (expQ.size() == 0) begin
      compare("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = expQ.pop_front();
    compare({e.name, ".pc_src"}, {31'd0, bus.pc_src}, {31'd0, e.pcSrc});
    compare({e.name, ".redirect_sel"}, {30'd0, bus.redirect_sel}, {30'd0, e.sel});
    compare({e.name, ".is_j"}, {31'd0, bus.is_j}, {31'd0, e.isJ});
    compare({e.name, ".if_flush"}, {31'd0, bus.if_flush}, {31'd0, e.pcSrc});
    compare({e.name, ".pred_taken"}, {31'd0, bus.pred_taken}, {31'd0, e.pred});
    compare({e.name, ".branch_cnt"}, 32'(bus.branch_cnt), e.bc);
    compare({e.name, ".mispred_cnt"}, 32'(bus.mispred_cnt), e.mc);
  endtask

  task automatic modelUpdate(input vecT v);
    logic tk;
    logic [IDX_W-1:0] idx;
    if (v.valid && !v.stall && (v.opcode == 6'd4 || v.opcode == 6'd5)) begin
      tk  = (v.opcode == 6'd4) ? (v.rd1 == v.rd2) : (v.rd1 != v.rd2);
      idx = v.idPc[IDX_W+1:2];
      if (tk && modelBht[idx] < 2'd3) modelBht[idx] = modelBht[idx] + 2'd1;
      if (!tk && modelBht[idx] > 2'd0) modelBht[idx] = modelBht[idx] - 2'd1;
      if (PERF_EN) begin
        if (modelBranchCnt < CNT_MAX) modelBranchCnt++;
        if (tk != v.pt && modelMispredCnt < CNT_MAX) modelMispredCnt++;
      end
    end
  endtask

  task automatic runVec(input vecT v);
    applyStimulus(v);
    checkOutput();
    modelUpdate(v);
  endtask

  initial begin
    vecT v;
    resetModel();
    rst_n             = 1'b0;
    bus.if_pc         = '0;
    bus.id_valid      = 1'b0;
    bus.id_stall      = 1'b0;
    bus.id_opcode     = '0;
    bus.id_funct      = '0;
    bus.id_pc         = '0;
    bus.id_pred_taken = 1'b0;
    bus.read_data1    = '0;
    bus.read_data2    = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state: every index predicts not-taken, counters clear.
    for (int i = 0; i < BHT_DEPTH; i++) begin
      v = mkVec($sformatf("reset_idx%0d", i), 6'd0, 0, 0, 32'(i * 4), 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      runVec(v);
    end

    addVec("beq_taken_mispred", 6'd4, 6'd0, 5, 5, 32'h40, 32'h40, 0, 1, 0, 1, 2'b00, 0);
    addVec("bne_taken_ok1", 6'd5, 6'd0, 3, 7, 32'h40, 32'h40, 1, 1, 0, 0, 2'b00, 0);
    addVec("bne_taken_ok2", 6'd5, 6'd0, 3, 7, 32'h40, 32'h40, 1, 1, 0, 0, 2'b00, 0);
    addVec("bne_taken_ok3", 6'd5, 6'd0, 3, 7, 32'h40, 32'h40, 1, 1, 0, 0, 2'b00, 0);
    addVec("beq_nt_mispred", 6'd4, 6'd0, 1, 2, 32'h40, 32'h40, 1, 1, 0, 1, 2'b01, 0);
    addVec("jr", 6'd0, 6'd8, 1, 1, 32'h40, 32'h40, 0, 1, 0, 1, 2'b11, 1);
    addVec("jal", 6'd3, 6'd0, 1, 1, 32'h40, 32'h40, 0, 1, 0, 1, 2'b10, 1);
    addVec("j", 6'd2, 6'd0, 0, 0, 32'h80, 32'h40, 1, 1, 0, 1, 2'b10, 1);
    addVec("rtype_add", 6'd0, 6'h20, 4, 4, 32'h40, 32'h40, 0, 1, 0, 0, 2'b00, 0);
    addVec("beq_invalid", 6'd4, 6'd0, 6, 6, 32'h40, 32'h40, 0, 0, 0, 0, 2'b00, 0);
    addVec("beq_msb_diff", 6'd4, 6'd0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h44, 32'h44, 0, 1, 0, 0, 2'b00, 0);
    addVec("bne_msb_diff", 6'd5, 6'd0, 32'h8000_0000, 32'h0, 32'h44, 32'h44, 0, 1, 0, 1, 2'b00, 0);
    addVec("lw_nonctrl", 6'h23, 6'd0, 1, 2, 32'h44, 32'h44, 1, 1, 0, 0, 2'b00, 0);
    addVec("bne_nt_mispred", 6'd5, 6'd0, 9, 9, 32'h40, 32'h40, 1, 1, 0, 1, 2'b01, 0);
    addVec("jr_stalled", 6'd0, 6'd8, 0, 0, 32'h40, 32'h40, 0, 1, 1, 0, 2'b00, 0);
    addVec("idle_check40", 6'd0, 6'd0, 0, 0, 32'h40, 32'h40, 0, 0, 0, 0, 2'b00, 0);
    foreach (vecs[i]) runVec(vecs[i]);

    // Stalled beq trains only once, in its first unstalled cycle.
    for (int i = 0; i < 4; i++) begin
      v = mkVec($sformatf("stall%0d", i), 6'd4, 8, 8, 32'h48, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
      runVec(v);
    end
    runVec(mkVec("stall_release", 6'd4, 8, 8, 32'h48, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00));
    runVec(mkVec("post_release", 6'd0, 0, 0, 32'h48, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
    runVec(mkVec("bne_after_stall", 6'd5, 4, 4, 32'h48, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01));
    runVec(mkVec("single_train", 6'd0, 0, 0, 32'h48, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));

    // Twenty mispredicts push both counters into saturation.
    for (int i = 0; i < 20; i++) begin
      v = mkVec($sformatf("sat%0d", i), 6'd4, 1, 1, 32'h4C, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00);
      runVec(v);
    end
    runVec(mkVec("sat_hold", 6'd0, 0, 0, 32'h4C, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));

    // Asynchronous reset between clock edges.
    @(negedge clk);
    bus.id_valid = 1'b0;
    bus.if_pc    = 32'h4C;
    #2 rst_n = 1'b0;
    #1;
    compare("async_rst.branch_cnt", 32'(bus.branch_cnt), 32'd0);
    compare("async_rst.mispred_cnt", 32'(bus.mispred_cnt), 32'd0);
    compare("async_rst.pred_taken", {31'd0, bus.pred_taken}, 32'd0);
    resetModel();
    @(negedge clk);
    rst_n = 1'b1;
    runVec(mkVec("after_rst", 6'd4, 2, 2, 32'h4C, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00));
    runVec(mkVec("after_rst_pred", 6'd0, 0, 0, 32'h4C, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

ID-stage branch/jump resolver with a direct-mapped bimodal branch history table (BHT). It compares the two register operands, decides branch/jump outcome and redirect source, and generates the IF flush. It trains a table of 2-bit saturating counters that supplies a taken prediction to the IF stage. Optional saturating performance counters track resolved branches and mispredicts.

## Interface
- `DATA_W`, 32: register operand width.
- `PC_W`, 32: program counter width.
- `BHT_DEPTH`, 16: number of BHT entries; power of two, ≥2.
- `CNT_W`, 16: performance counter width.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `if_pc` in PC_W: PC of the instruction in IF (prediction lookup).
- `pred_taken` out 1: BHT prediction for `if_pc`.
- `id_valid` in 1: ID holds a valid instruction.
- `id_stall` in 1: ID stalled this cycle (hazard); suppresses resolution.
- `id_opcode` in 6: instruction opcode.
- `id_funct` in 6: R-type funct field.
- `id_pc` in PC_W: PC of the ID instruction.
- `id_pred_taken` in 1: prediction carried down the pipe with the instruction.
- `read_data1`, `read_data2` in DATA_W: rs/rt operands, already forwarded.
- `pc_src` out 1: redirect the PC this cycle.
- `redirect_sel` out 2: 00 branch target, 01 fall-through (`id_pc`+4), 10 jump target, 11 register (jr).
- `is_j` out 1: redirect is jump-class (j/jal/jr).
- `if_flush` out 1: flush the IF/ID register.
- `branch_cnt` out CNT_W: resolved conditional branches.
- `mispred_cnt` out CNT_W: mispredicted conditional branches.

## Operation
- Decode:
  - beq = 000100.
  - bne = 000101.
  - j = 000010.
  - jal = 000011.
  - jr = opcode 000000 with funct 001000.
  - All other encodings are non-control-flow.
- `resolve = id_valid & ~id_stall`. While `resolve`=0, `pc_src`, `is_j` and `if_flush` are 0, and no state changes.
- Branch outcome:
  - `taken = (read_data1 == read_data2)` for beq.
  - `taken = (read_data1 != read_data2)` for bne.
  - Comparison is full DATA_W.
- Mispredict is `taken != id_pred_taken`. On a mispredict: `pc_src`=1, `redirect_sel`=00 if taken, else 01.
- Correctly predicted branch: `pc_src`=0. IF already followed the prediction.
- j/jal: `pc_src`=1, `redirect_sel`=10, `is_j`=1. jr: `pc_src`=1, `redirect_sel`=11, `is_j`=1. Jumps never touch the BHT.
- `if_flush = pc_src`.
- When `pc_src`=0, `redirect_sel` = 00 (don't-care for consumers, fixed for checking).
- BHT indexing: `pc[log2(BHT_DEPTH)+1:2]`.
- `pred_taken` = bit 1 of the entry addressed by `if_pc`.
- Training: on a resolved beq/bne, the entry addressed by `id_pc` increments if taken (saturating at 11) and decrements if not taken (saturating at 00).
- Perf counters:
  - `branch_cnt` increments on every resolved beq/bne.
  - `mispred_cnt` increments on every mispredict.
  - Both saturate at all-ones and do not wrap.

## Timing
- Reset: every BHT entry = 01 (weakly not-taken), so `pred_taken`=0. Both perf counters = 0.
- Reset assertion mid-operation clears state immediately, without waiting for a clock edge.
- `pc_src`, `redirect_sel`, `is_j` and `if_flush` are combinational from ID inputs, with zero-cycle latency.
- `pred_taken` is combinational from `if_pc` and the registered BHT.
- BHT and counter updates commit at the rising edge and are visible from the next cycle.
- Simultaneous IF lookup and ID update of the same entry: `pred_taken` returns the pre-update value (read-before-write).
- A stalled instruction resolves exactly once, in its first cycle with `id_stall`=0. Multi-cycle stalls cause no double-training.

## Configuration
- `BRANCH_PERF_CNT_EN` defined: `branch_cnt` and `mispred_cnt` registers and increment logic are present.
- Undefined: both outputs are tied to 0 and no counter flops are synthesised. BHT and redirect behaviour are unchanged.

## Test plan
- Reset, then sweep `if_pc` across all BHT indices → `pred_taken`=0 everywhere; `branch_cnt`=`mispred_cnt`=0.
- beq at `id_pc`=0x40, operands 5/5, `id_pred_taken`=0:
  - Same cycle: `pc_src`=1, `redirect_sel`=00, `if_flush`=1.
  - Next cycle, `if_pc`=0x40: `pred_taken`=1.
  - Counters: `branch_cnt`=1, `mispred_cnt`=1.
- bne at 0x40, operands 3/7, `id_pred_taken`=1, repeated 3×:
  - `pc_src`=0 each time.
  - Entry saturates at 11.
  - Then beq with operands 1/2 and `id_pred_taken`=1 → `pc_src`=1, `redirect_sel`=01, entry becomes 10.
- jr (000000/001000) → `pc_src`=1, `redirect_sel`=11, `is_j`=1. jal → `redirect_sel`=10. The BHT entry at `id_pc` is unchanged for both.
- beq held with `id_stall`=1 for 4 cycles, then released:
  - Outputs stay 0 during the stall.
  - Exactly one BHT update and one `branch_cnt` increment.
  - Same-cycle `if_pc`=`id_pc` lookup returns the old prediction.
- With `CNT_W`=4 and `BRANCH_PERF_CNT_EN` defined: 20 mispredicted branches → both counters hold 0xF. Assert `rst_n` mid-cycle → both counters are 0 immediately.
